// File: rtl/vga_console_pkg.sv
// Shared definitions for the VGA text console character sequencer.
// Contents: sequencer state enum, control-code constants, default console
// geometry, the blank cell value and the row/column to cell address helper.
package vga_console_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitVb = 2'd1,
    StScroll = 2'd2,
    StClear  = 2'd3
  } seq_state_e;

  localparam int unsigned DEFAULT_NUM_ROWS = 3;
  localparam int unsigned DEFAULT_NUM_COLS = 10;

  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_FF    = 7'h0C;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_TILDE = 7'h7E;

  localparam logic [8:0] BLANK_CELL = {2'b00, CH_SPACE};

  // row*10 + col as shift-add (x8 + x2); tied to the 10-column layout.
  function automatic logic [4:0] cell_addr(input logic [1:0] row, input logic [3:0] col);
    logic [4:0] r;
    r = {3'b000, row};
    return (r << 3) + (r << 1) + {1'b0, col};
  endfunction

endpackage

// File: rtl/console_char_fifo.sv
// Small character FIFO feeding the console sequencer.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (resets to empty)
//   push, push_data - write request and entry; ignored while full
//   pop             - consume the head entry; ignored while empty
//   head            - current head entry (combinational)
//   full, empty     - occupancy flags
module console_char_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  // One extra wrap bit distinguishes full from empty.
  logic [PtrW:0]    wptr_q, rptr_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign head  = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vga_console_seq.sv
// Character-stream sequencer for the 3x10 VGA text console. Buffers incoming
// characters, tracks the cursor, writes glyph cells into the text buffer and
// handles CR/LF/BS/FF. Scroll and clear sweep the whole buffer, starting only
// inside vertical blank.
// Ports:
//   clk, rst_n                        - clock, asynchronous active-low reset
//   char_valid/char_code/char_color   - character input; char_ready = FIFO not full
//   vblank                            - vertical blank level
//   buf_raddr/buf_rdata               - text buffer read port (used by scroll)
//   buf_we/buf_waddr/buf_wdata        - registered text buffer write port
//   cursor_row/cursor_col             - cursor position
//   busy                              - work pending or write in flight
module vga_console_seq
  import vga_console_pkg::*;
#(
  parameter int unsigned NUM_ROWS   = DEFAULT_NUM_ROWS,
  parameter int unsigned NUM_COLS   = DEFAULT_NUM_COLS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [6:0] char_code,
  input  logic [1:0] char_color,
  output logic       char_ready,
  input  logic       vblank,
  output logic [4:0] buf_raddr,
  input  logic [8:0] buf_rdata,
  output logic       buf_we,
  output logic [4:0] buf_waddr,
  output logic [8:0] buf_wdata,
  output logic [1:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  localparam logic [4:0] LastIdx    = 5'(NUM_ROWS * NUM_COLS - 1);
  localparam logic [4:0] ShiftCells = 5'((NUM_ROWS - 1) * NUM_COLS);
  localparam logic [4:0] RowStride  = 5'(NUM_COLS);
  localparam logic [1:0] LastRow    = 2'(NUM_ROWS - 1);
  localparam logic [3:0] LastCol    = 4'(NUM_COLS - 1);

  seq_state_e state_q, state_d;
  seq_state_e op_q, op_d;        // pending sweep once vblank arrives
  logic [4:0] idx_q, idx_d;
  logic [1:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic       we_q, we_d;
  logic [4:0] waddr_q, waddr_d;
  logic [8:0] wdata_q, wdata_d;

  logic       fifo_full, fifo_empty, pop, advance;
  logic [8:0] fifo_head;
  logic [6:0] code;

  console_char_fifo #(
    .Width(9),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (char_valid),
    .push_data({char_color, char_code}),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign code = fifo_head[6:0];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pop       = 1'b0;
    advance   = 1'b0;
    buf_raddr = '0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (code >= CH_SPACE && code <= CH_TILDE) begin
            we_d    = 1'b1;
            waddr_d = cell_addr(row_q, col_q);
            wdata_d = fifo_head;
            if (col_q == LastCol) begin
              col_d   = '0;
              advance = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (code)
              CH_LF: begin
                col_d   = '0;
                advance = 1'b1;
              end
              CH_CR: col_d = '0;
              CH_BS: if (col_q != '0) col_d = col_q - 1'b1;
              CH_FF: begin
                row_d   = '0;
                col_d   = '0;
                op_d    = StClear;
                state_d = StWaitVb;
              end
              default: ;
            endcase
          end
          // Line advance past the bottom row keeps the row and requests a scroll.
          if (advance) begin
            if (row_q != LastRow) begin
              row_d = row_q + 1'b1;
            end else begin
              op_d    = StScroll;
              state_d = StWaitVb;
            end
          end
        end
      end
      StWaitVb: begin
        if (vblank) begin
          state_d = op_q;
          idx_d   = '0;
        end
      end
      StScroll, StClear: begin
        we_d    = 1'b1;
        waddr_d = idx_q;
        // Scroll copies the row below; the bottom row and clear write blanks.
        if (state_q == StScroll && idx_q < ShiftCells) begin
          buf_raddr = idx_q + RowStride;
          wdata_d   = buf_rdata;
        end else begin
          wdata_d = BLANK_CELL;
        end
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= StScroll;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign char_ready = !fifo_full;
  assign buf_we     = we_q;
  assign buf_waddr  = waddr_q;
  assign buf_wdata  = wdata_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = !fifo_empty || (state_q != StIdle) || we_q;

endmodule
